// File: rtl/core_types_pkg.sv
// ---------------------------------------------------------------------------
// core_types_pkg
// Shared rename-stage types and sizing constants.
//   phys_reg_tag_t    : physical register tag (log2 NUM_PHYS_REGS bits)
//   free_list_ptr_t   : head/tail index into the free list, wraps mod depth
//   free_list_count_t : free list occupancy, one bit wider than the pointer
//                       so that the full value (FREE_LIST_DEPTH) is representable
// ---------------------------------------------------------------------------
package core_types_pkg;

    localparam int NUM_ARCH_REGS    = 32;
    localparam int NUM_PHYS_REGS    = 64;
    localparam int PHYS_REG_TAG_W   = $clog2(NUM_PHYS_REGS);

    typedef logic [PHYS_REG_TAG_W-1:0] phys_reg_tag_t;

    // Must be a power of two so the pointers can wrap by plain overflow.
    localparam int FREE_LIST_DEPTH  = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int FREE_LIST_PTR_W  = $clog2(FREE_LIST_DEPTH);
    localparam int FREE_LIST_CNT_W  = FREE_LIST_PTR_W + 1;

    typedef logic [FREE_LIST_PTR_W-1:0] free_list_ptr_t;
    typedef logic [FREE_LIST_CNT_W-1:0] free_list_count_t;

endpackage

// File: rtl/phys_reg_free_list.sv
// ---------------------------------------------------------------------------
// phys_reg_free_list
// Circular FIFO of free physical register tags feeding rename/dispatch.
//
// Ports:
//   CLK, RST                             clock, synchronous active-high reset
//   dequeue_valid        (in)            dispatch consumes the head tag
//   dequeue_ready        (out)           a tag is available and no revert is pending
//   dequeue_phys_reg_tag (out)           tag at head (combinational from state)
//   commit_enqueue_valid (in)            ROB commit returns an old dest tag
//   commit_enqueue_phys_reg_tag (in)     tag being freed, written at tail
//   revert_valid         (in)            map-table revert this cycle
//   revert_speculated_dest_phys_reg_tag  tag pushed back in front of head
//   free_count           (out)           registered occupancy
//   overflow_error       (out)           sticky: an enqueue was dropped when full
// ---------------------------------------------------------------------------
module phys_reg_free_list
    import core_types_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             dequeue_valid,
    output logic             dequeue_ready,
    output phys_reg_tag_t    dequeue_phys_reg_tag,
    input  logic             commit_enqueue_valid,
    input  phys_reg_tag_t    commit_enqueue_phys_reg_tag,
    input  logic             revert_valid,
    input  phys_reg_tag_t    revert_speculated_dest_phys_reg_tag,
    output free_list_count_t free_count,
    output logic             overflow_error
);

    localparam free_list_count_t DEPTH_C = free_list_count_t'(FREE_LIST_DEPTH);

    phys_reg_tag_t    r_entries [FREE_LIST_DEPTH];
    free_list_ptr_t   r_head;
    free_list_ptr_t   r_tail;
    free_list_count_t r_count;
    logic             r_overflow;

    logic             w_dequeue_fire;
    logic             w_revert_grant;
    logic             w_commit_grant;
    logic             w_enq_dropped;
    free_list_ptr_t   w_head_dec;
    free_list_ptr_t   w_head_nxt;
    free_list_count_t w_count_nxt;

    // A revert retracts the dequeue that produced its tag, so dispatch must
    // not take a fresh tag in the same cycle.
    assign dequeue_ready        = (r_count != '0) & ~revert_valid;
    assign dequeue_phys_reg_tag = r_entries[r_head];
    assign free_count           = r_count;
    assign overflow_error       = r_overflow;

    always_comb begin
        w_dequeue_fire = dequeue_valid & dequeue_ready;
        // Revert is granted first; commit only gets a slot if one remains
        // after the revert. This also keeps the revert slot (head-1) and
        // the commit slot (tail) from ever colliding.
        w_revert_grant = revert_valid & (r_count < DEPTH_C);
        w_commit_grant = commit_enqueue_valid &
                         ((r_count + free_list_count_t'(w_revert_grant)) < DEPTH_C);
        w_enq_dropped  = (revert_valid & ~w_revert_grant) |
                         (commit_enqueue_valid & ~w_commit_grant);

        w_head_dec = r_head - free_list_ptr_t'(1);
        w_head_nxt = r_head;
        if (w_revert_grant)
            w_head_nxt = w_head_dec;
        else if (w_dequeue_fire)
            w_head_nxt = r_head + free_list_ptr_t'(1);

        w_count_nxt = r_count
                    + free_list_count_t'(w_commit_grant)
                    + free_list_count_t'(w_revert_grant)
                    - free_list_count_t'(w_dequeue_fire);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < FREE_LIST_DEPTH; i++)
                r_entries[i] <= phys_reg_tag_t'(NUM_ARCH_REGS + i);
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= DEPTH_C;
            r_overflow <= 1'b0;
        end else begin
            if (w_revert_grant)
                r_entries[w_head_dec] <= revert_speculated_dest_phys_reg_tag;
            if (w_commit_grant) begin
                r_entries[r_tail] <= commit_enqueue_phys_reg_tag;
                r_tail            <= r_tail + free_list_ptr_t'(1);
            end
            r_head  <= w_head_nxt;
            r_count <= w_count_nxt;
            if (w_enq_dropped)
                r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// ---------------------------------------------------------------------------
// tb_phys_reg_free_list
// Directed stimulus with a scoreboard queue: each driven cycle pushes the
// outputs expected during that cycle; a monitor on the falling edge pops
// and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_phys_reg_free_list;
    import core_types_pkg::*;

    logic             CLK = 1'b0;
    logic             RST;
    logic             dequeue_valid;
    logic             dequeue_ready;
    phys_reg_tag_t    dequeue_phys_reg_tag;
    logic             commit_enqueue_valid;
    phys_reg_tag_t    commit_enqueue_phys_reg_tag;
    logic             revert_valid;
    phys_reg_tag_t    revert_speculated_dest_phys_reg_tag;
    free_list_count_t free_count;
    logic             overflow_error;

    phys_reg_free_list dut (
        .CLK                                 (CLK),
        .RST                                 (RST),
        .dequeue_valid                       (dequeue_valid),
        .dequeue_ready                       (dequeue_ready),
        .dequeue_phys_reg_tag                (dequeue_phys_reg_tag),
        .commit_enqueue_valid                (commit_enqueue_valid),
        .commit_enqueue_phys_reg_tag         (commit_enqueue_phys_reg_tag),
        .revert_valid                        (revert_valid),
        .revert_speculated_dest_phys_reg_tag (revert_speculated_dest_phys_reg_tag),
        .free_count                          (free_count),
        .overflow_error                      (overflow_error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string name;
        logic  rdy;
        logic  chk_tag;
        int    tag;
        int    cnt;
        logic  ovf;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: outputs are stable at the falling edge, half a cycle after
    // the driver applied this cycle's inputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (dequeue_ready !== e.rdy) begin
                    n_fail++;
                    $display("FAIL %s ready: got %b want %b", e.name, dequeue_ready, e.rdy);
                end
                n_checks++;
                if (int'(free_count) != e.cnt || $isunknown(free_count)) begin
                    n_fail++;
                    $display("FAIL %s count: got %0d want %0d", e.name, free_count, e.cnt);
                end
                n_checks++;
                if (overflow_error !== e.ovf) begin
                    n_fail++;
                    $display("FAIL %s overflow: got %b want %b", e.name, overflow_error, e.ovf);
                end
                if (e.chk_tag) begin
                    n_checks++;
                    if (int'(dequeue_phys_reg_tag) != e.tag || $isunknown(dequeue_phys_reg_tag)) begin
                        n_fail++;
                        $display("FAIL %s tag: got 0x%0h want 0x%0h", e.name,
                                 dequeue_phys_reg_tag, e.tag);
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs (we sit 1ns after a rising edge), record the
    // outputs expected during it, then advance past the next rising edge.
    task automatic cyc(input string name,
                       input logic dv, input logic cv, input int ctag,
                       input logic rv, input int rtag,
                       input logic e_rdy, input logic e_chk, input int e_tag,
                       input int e_cnt, input logic e_ovf);
        exp_t e;
        dequeue_valid                       = dv;
        commit_enqueue_valid                = cv;
        commit_enqueue_phys_reg_tag         = phys_reg_tag_t'(ctag);
        revert_valid                        = rv;
        revert_speculated_dest_phys_reg_tag = phys_reg_tag_t'(rtag);
        e.name = name; e.rdy = e_rdy; e.chk_tag = e_chk; e.tag = e_tag;
        e.cnt  = e_cnt; e.ovf = e_ovf;
        q.push_back(e);
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RST                  = 1'b1;
        dequeue_valid        = 1'b0;
        commit_enqueue_valid = 1'b0;
        revert_valid         = 1'b0;
        commit_enqueue_phys_reg_tag         = '0;
        revert_speculated_dest_phys_reg_tag = '0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    initial begin
        do_reset();

        // Reset state, then drain all 32 tags in order.
        cyc("reset_state", 0, 0, 0, 0, 0, 1, 1, 'h20, 32, 0);
        for (int i = 0; i < 32; i++)
            cyc("drain", 1, 0, 0, 0, 0, 1, 1, 'h20 + i, 32 - i, 0);
        cyc("empty_not_ready", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Commit into an empty list: visible only the following cycle.
        cyc("empty_commit", 0, 1, 'h05, 0, 0, 0, 0, 0, 0, 0);
        cyc("after_empty_commit", 0, 0, 0, 0, 0, 1, 1, 'h05, 1, 0);

        // Revert undoes the matching dequeues exactly.
        do_reset();
        cyc("rv_deq0", 1, 0, 0, 0, 0, 1, 1, 'h20, 32, 0);
        cyc("rv_deq1", 1, 0, 0, 0, 0, 1, 1, 'h21, 31, 0);
        cyc("rv_rev21", 0, 0, 0, 1, 'h21, 0, 1, 'h22, 30, 0);
        cyc("rv_rev20", 0, 0, 0, 1, 'h20, 0, 1, 'h21, 31, 0);
        cyc("rv_redeq20", 1, 0, 0, 0, 0, 1, 1, 'h20, 32, 0);
        cyc("rv_redeq21", 1, 0, 0, 0, 0, 1, 1, 'h21, 31, 0);
        cyc("rv_after", 0, 0, 0, 0, 0, 1, 1, 'h22, 30, 0);

        // Revert + dequeue + commit together at count 30.
        do_reset();
        cyc("tri_deq0", 1, 0, 0, 0, 0, 1, 1, 'h20, 32, 0);
        cyc("tri_deq1", 1, 0, 0, 0, 0, 1, 1, 'h21, 31, 0);
        cyc("tri_all", 1, 1, 'h07, 1, 'h22, 0, 1, 'h22, 30, 0);
        // Head now at index 1 (0x22), then 0x22..0x3F, then 0x07 at index 0.
        for (int i = 0; i < 32; i++)
            cyc("tri_drain", 1, 0, 0, 0, 0, 1, 1,
                (i == 0) ? 'h22 : (i == 31) ? 'h07 : 'h21 + i, 32 - i, 0);
        cyc("tri_empty", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Commit to a full list is dropped and sets the sticky error.
        do_reset();
        cyc("full_commit", 0, 1, 'h01, 0, 0, 1, 1, 'h20, 32, 0);
        cyc("ovf_set", 1, 0, 0, 0, 0, 1, 1, 'h20, 32, 1);
        cyc("ovf_sticky", 1, 0, 0, 0, 0, 1, 1, 'h21, 31, 1);
        cyc("ovf_sticky2", 0, 0, 0, 0, 0, 1, 1, 'h22, 30, 1);
        do_reset();
        cyc("ovf_cleared", 0, 0, 0, 0, 0, 1, 1, 'h20, 32, 0);

        // Revert + commit at count 31: revert fills the list, commit dropped.
        cyc("rc_deq", 1, 0, 0, 0, 0, 1, 1, 'h20, 32, 0);
        cyc("rc_both", 0, 1, 'h09, 1, 'h20, 0, 1, 'h21, 31, 0);
        cyc("rc_after", 0, 0, 0, 0, 0, 1, 1, 'h20, 32, 1);

        // Reset asserted with requests pending discards them.
        RST = 1'b1; dequeue_valid = 1'b1; commit_enqueue_valid = 1'b1;
        commit_enqueue_phys_reg_tag = 6'h11;
        @(posedge CLK); #1;
        RST = 1'b0;
        cyc("mid_reset", 0, 0, 0, 0, 0, 1, 1, 'h20, 32, 0);

        // Wrap-around: one dequeue, then 40 dequeue+commit pairs at count 31.
        cyc("wrap_pre", 1, 0, 0, 0, 0, 1, 1, 'h20, 32, 0);
        for (int i = 0; i < 40; i++)
            cyc("wrap", 1, 1, i, 0, 0, 1, 1, (i < 31) ? 'h21 + i : i - 31, 31, 0);
        cyc("wrap_after", 0, 0, 0, 0, 0, 1, 1, 'h09, 31, 0);

        @(negedge CLK);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
